decode_stage_param: RTL and testbench

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

---
 rtl/decode_stage_param_pkg.sv | 26 ++
 rtl/decode_stage_param_if.sv | 30 +++
 rtl/decode_stage_param_fwd_select.sv | 32 +++
 rtl/decode_stage_param.sv | 136 +++++++++++++
 tb/tb_decode_stage_param.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_param_pkg.sv
// Shared types and constants for the decode stage: FSM states and the
// exception codes raised by decode itself.
package decode_stage_param_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LUSE = 1'b1
  } state_t;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_ECALL   = 4'd8;

  // An upstream exception wins over anything decode discovers.
  function automatic logic [3:0] exc_code_sel(
    input logic       up_valid,
    input logic [3:0] up_code,
    input logic       illegal,
    input logic       ecall
  );
    if (up_valid)     return up_code;
    else if (illegal) return EXC_ILLEGAL;
    else if (ecall)   return EXC_ECALL;
    else              return 4'd0;
  endfunction

endpackage

// File: rtl/decode_stage_param_if.sv
// ID/EX pipeline register bus: the decode stage is the master,
// the execute stage is the slave and supplies out_ready.
interface decode_stage_param_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 48
);
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [4:0]        out_wd;
  logic              out_wb;
  logic              out_mem_read;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_exc_valid;
  logic [3:0]        out_exc_code;

  modport master (
    output out_valid, out_pc, out_rs1_val, out_rs2_val, out_wd, out_wb,
           out_mem_read, out_ctrl, out_exc_valid, out_exc_code,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_wd, out_wb,
           out_mem_read, out_ctrl, out_exc_valid, out_exc_code,
    output out_ready
  );
endinterface

// File: rtl/decode_stage_param_fwd_select.sv
// Operand bypass selector: the lowest-index (youngest) matching channel wins
// over the register file; register x0 always reads as zero.
module fwd_select #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]            rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [NUM_FWD-1:0]    fwd_valid,
  input  logic [NUM_FWD-1:0]    fwd_wb,
  input  logic [NUM_FWD*5-1:0]  fwd_wd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]       val
);
  logic [NUM_FWD-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = fwd_valid[gi] & fwd_wb[gi] & (fwd_wd[gi*5 +: 5] == rs);
    end
  endgenerate

  // Walk from oldest to youngest so the youngest hit overwrites.
  always_comb begin
    val = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) val = fwd_data[i*XLEN +: XLEN];
    end
    if (rs == 5'd0) val = '0;
  end
endmodule

// File: rtl/decode_stage_param.sv
// Decode stage: operand fetch with bypass, load-use interlock and the
// ID/EX pipeline register.
module decode_stage_param
  import decode_stage_param_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CTRL_W   = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    in_exc_valid,
  input  logic [3:0]              in_exc_code,
  input  logic [4:0]              dec_rs1,
  input  logic [4:0]              dec_rs2,
  input  logic                    dec_use1,
  input  logic                    dec_use2,
  input  logic [4:0]              dec_wd,
  input  logic                    dec_wb,
  input  logic                    dec_mem_read,
  input  logic                    dec_illegal,
  input  logic                    dec_ecall,
  input  logic [CTRL_W-1:0]       dec_ctrl,
  output logic [4:0]              rf_rs1_addr,
  output logic [4:0]              rf_rs2_addr,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_wb,
  input  logic [NUM_FWD*5-1:0]    fwd_wd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  decode_stage_param_if.master    id_ex
);
  // A zero-latency build still needs a legal one-bit counter.
  localparam int CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              valid_reg, wb_reg, mem_read_reg, exc_valid_reg;
  logic [XLEN-1:0]   pc_reg, rs1_val_reg, rs2_val_reg;
  logic [4:0]        wd_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [3:0]        exc_code_reg;

  logic [XLEN-1:0] rs1_val_next, rs2_val_next;
  logic            advance, luse_hit, accept;

  assign rf_rs1_addr = dec_rs1;
  assign rf_rs2_addr = dec_rs2;

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs(dec_rs1), .rf_data(rf_rs1_data), .fwd_valid(fwd_valid), .fwd_wb(fwd_wb),
    .fwd_wd(fwd_wd), .fwd_data(fwd_data), .val(rs1_val_next)
  );

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs(dec_rs2), .rf_data(rf_rs2_data), .fwd_valid(fwd_valid), .fwd_wb(fwd_wb),
    .fwd_wd(fwd_wd), .fwd_data(fwd_data), .val(rs2_val_next)
  );

  // A load sitting in ID/EX cannot bypass its data yet, so its consumer waits.
  assign advance  = id_ex.out_ready | ~valid_reg;
  assign luse_hit = (LOAD_LAT > 0) & valid_reg & mem_read_reg & wb_reg & (wd_reg != 5'd0) &
                    ((dec_use1 & (dec_rs1 == wd_reg)) | (dec_use2 & (dec_rs2 == wd_reg)));
  assign in_ready = advance & (state_reg == RUN) & ~luse_hit;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RUN;
      cnt_reg       <= '0;
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rs1_val_reg   <= '0;
      rs2_val_reg   <= '0;
      wd_reg        <= '0;
      wb_reg        <= 1'b0;
      mem_read_reg  <= 1'b0;
      ctrl_reg      <= '0;
      exc_valid_reg <= 1'b0;
      exc_code_reg  <= '0;
    end else if (flush) begin
      state_reg     <= RUN;
      cnt_reg       <= '0;
      valid_reg     <= 1'b0;
      exc_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (in_valid & luse_hit & advance) begin
            state_reg <= LUSE;
            cnt_reg   <= CNT_LOAD;
          end
        end
        LUSE: begin
          if (advance) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_reg <= RUN;
          end
        end
      endcase

      if (accept) begin
        valid_reg     <= 1'b1;
        pc_reg        <= in_pc;
        rs1_val_reg   <= rs1_val_next;
        rs2_val_reg   <= rs2_val_next;
        wd_reg        <= dec_wd;
        wb_reg        <= dec_wb;
        mem_read_reg  <= dec_mem_read;
        ctrl_reg      <= dec_ctrl;
        exc_valid_reg <= in_exc_valid | dec_illegal | dec_ecall;
        exc_code_reg  <= exc_code_sel(in_exc_valid, in_exc_code, dec_illegal, dec_ecall);
      end else if (advance) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign id_ex.out_valid     = valid_reg;
  assign id_ex.out_pc        = pc_reg;
  assign id_ex.out_rs1_val   = rs1_val_reg;
  assign id_ex.out_rs2_val   = rs2_val_reg;
  assign id_ex.out_wd        = wd_reg;
  assign id_ex.out_wb        = wb_reg;
  assign id_ex.out_mem_read  = mem_read_reg;
  assign id_ex.out_ctrl      = ctrl_reg;
  assign id_ex.out_exc_valid = exc_valid_reg;
  assign id_ex.out_exc_code  = exc_code_reg;
endmodule

// File: tb/tb_decode_stage_param.sv
// Scoreboard bench for decode_stage_param: directed hazard/bypass cases
// followed by randomized traffic against a cycle-level behavioural model.
module tb_decode_stage_param;
  localparam int XLEN = 64, NUM_FWD = 2, LOAD_LAT = 2, CTRL_W = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    in_valid, in_ready, in_exc_valid;
  logic [XLEN-1:0]         in_pc;
  logic [3:0]              in_exc_code;
  logic [4:0]              dec_rs1, dec_rs2, dec_wd;
  logic                    dec_use1, dec_use2, dec_wb, dec_mem_read, dec_illegal, dec_ecall;
  logic [CTRL_W-1:0]       dec_ctrl;
  logic [4:0]              rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0]         rf_rs1_data, rf_rs2_data;
  logic [NUM_FWD-1:0]      fwd_valid, fwd_wb;
  logic [NUM_FWD*5-1:0]    fwd_wd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush;

  decode_stage_param_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  // Register file model answers whatever address the DUT presents.
  logic [XLEN-1:0] rf_mem [32];
  assign rf_rs1_data = rf_mem[rf_rs1_addr];
  assign rf_rs2_data = rf_mem[rf_rs2_addr];

  decode_stage_param #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_wd(dec_wd), .dec_wb(dec_wb), .dec_mem_read(dec_mem_read),
    .dec_illegal(dec_illegal), .dec_ecall(dec_ecall), .dec_ctrl(dec_ctrl),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .fwd_valid(fwd_valid), .fwd_wb(fwd_wb), .fwd_wd(fwd_wd), .fwd_data(fwd_data),
    .flush(flush), .id_ex(bus)
  );

  typedef struct {
    logic [XLEN-1:0]   pc, v1, v2;
    logic [4:0]        wd;
    logic              wb, mr, ev;
    logic [CTRL_W-1:0] ctrl;
    logic [3:0]        ec;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Behavioural model state: what ID/EX holds and how many stall bubbles remain.
  bit              m_valid = 0;
  bit              m_load  = 0;
  logic [4:0]      m_wd    = '0;
  int              m_bub   = 0;
  logic [XLEN-1:0] pc_ctr  = 64'h1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_operand(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int c = 0; c < NUM_FWD; c++)
      if (fwd_valid[c] && fwd_wb[c] && fwd_wd[c*5 +: 5] == rs) return fwd_data[c*XLEN +: XLEN];
    return rf_mem[rs];
  endfunction

  task automatic idle();
    in_valid = 0; in_pc = pc_ctr; pc_ctr += 4; in_exc_valid = 0; in_exc_code = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_use1 = 0; dec_use2 = 0; dec_wd = 0; dec_wb = 0;
    dec_mem_read = 0; dec_illegal = 0; dec_ecall = 0; dec_ctrl = {16'($urandom), $urandom};
    fwd_valid = 0; fwd_wb = 0; fwd_wd = 0; fwd_data = 0; flush = 0; bus.out_ready = 1;
  endtask

  task automatic rand_inputs();
    in_valid     = ($urandom_range(0, 9) < 8);
    in_pc        = pc_ctr; pc_ctr += 4;
    in_exc_valid = ($urandom_range(0, 15) == 0);
    in_exc_code  = 4'($urandom);
    dec_rs1      = 5'($urandom_range(0, 7));
    dec_rs2      = 5'($urandom_range(0, 7));
    dec_use1     = 1'($urandom);
    dec_use2     = 1'($urandom);
    dec_wd       = 5'($urandom_range(0, 7));
    dec_wb       = 1'($urandom);
    dec_mem_read = ($urandom_range(0, 2) == 0);
    dec_illegal  = ($urandom_range(0, 11) == 0);
    dec_ecall    = ($urandom_range(0, 11) == 0);
    dec_ctrl     = {16'($urandom), $urandom};
    for (int c = 0; c < NUM_FWD; c++) begin
      fwd_valid[c]            = 1'($urandom);
      fwd_wb[c]               = 1'($urandom);
      fwd_wd[c*5 +: 5]        = 5'($urandom_range(0, 7));
      fwd_data[c*XLEN +: XLEN] = {$urandom, $urandom};
    end
    bus.out_ready = ($urandom_range(0, 3) != 0);
    flush         = ($urandom_range(0, 39) == 0);
  endtask

  // One clock of stimulus: check handshake against the model, push the
  // expected ID/EX contents on acceptance, then advance the model.
  task automatic step(input string tag, output bit got_ready, output bit got_valid);
    bit adv, hz, er, acc;
    exp_t e;
    @(negedge clk);
    got_ready = in_ready;
    got_valid = bus.out_valid;
    adv = bus.out_ready || !m_valid;
    hz  = m_valid && m_load && ((dec_use1 && dec_rs1 == m_wd) || (dec_use2 && dec_rs2 == m_wd));
    er  = (m_bub == 0) && adv && !hz;
    chk({tag, " in_ready"}, in_ready, er);
    chk({tag, " out_valid"}, bus.out_valid, m_valid);
    acc = in_valid && er && !flush;
    if (acc) begin
      e.pc = in_pc; e.v1 = ref_operand(dec_rs1); e.v2 = ref_operand(dec_rs2);
      e.wd = dec_wd; e.wb = dec_wb; e.mr = dec_mem_read; e.ctrl = dec_ctrl;
      if (in_exc_valid)     begin e.ev = 1; e.ec = in_exc_code; end
      else if (dec_illegal) begin e.ev = 1; e.ec = 4'd2; end
      else if (dec_ecall)   begin e.ev = 1; e.ec = 4'd8; end
      else                  begin e.ev = 0; e.ec = 4'd0; end
      sb.push_back(e);
    end
    if (flush) begin
      if (m_valid && !bus.out_ready && sb.size() > 0) e = sb.pop_back();
      m_valid = 0; m_bub = 0;
    end else if (m_bub > 0) begin
      m_bub--; m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_load = dec_mem_read && dec_wb && (dec_wd != 0); m_wd = dec_wd;
    end else if (hz && in_valid && adv) begin
      m_bub = LOAD_LAT; m_valid = 0;
    end else if (adv) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pop on every ID/EX transfer, and check stability across stalls.
  exp_t mon_e, snap;
  bit   prev_stall = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        chk("stall out_valid", bus.out_valid, 1'b1);
        chk("stall out_pc", bus.out_pc, snap.pc);
        chk("stall out_rs1_val", bus.out_rs1_val, snap.v1);
        chk("stall out_ctrl", bus.out_ctrl, snap.ctrl);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected output pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("out_pc", bus.out_pc, mon_e.pc);
          chk("out_rs1_val", bus.out_rs1_val, mon_e.v1);
          chk("out_rs2_val", bus.out_rs2_val, mon_e.v2);
          chk("out_wd", bus.out_wd, mon_e.wd);
          chk("out_wb_mr", {bus.out_wb, bus.out_mem_read}, {mon_e.wb, mon_e.mr});
          chk("out_ctrl", bus.out_ctrl, mon_e.ctrl);
          chk("out_exc", {bus.out_exc_valid, bus.out_exc_code}, {mon_e.ev, mon_e.ec});
          $display("txn pc=%h rs1=%h rs2=%h wd=%0d exc=%0b/%0d", bus.out_pc,
                   bus.out_rs1_val, bus.out_rs2_val, bus.out_wd, bus.out_exc_valid, bus.out_exc_code);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      snap.pc = bus.out_pc; snap.v1 = bus.out_rs1_val; snap.ctrl = bus.out_ctrl;
    end
  end

  initial begin
    bit r, v, accepted;
    int lows, bubbles;
    for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
    rf_mem[0] = 64'hDEAD_BEEF;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset out_exc_valid", bus.out_exc_valid, 1'b0);
    chk("reset out_exc_code", bus.out_exc_code, 4'd0);
    chk("reset out_pc", bus.out_pc, 64'd0);
    chk("reset out_rs1_val", bus.out_rs1_val, 64'd0);
    chk("reset out_wd_ctrl", {bus.out_wd, bus.out_ctrl}, 53'd0);
    chk("reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1;

    // Both channels target x5: youngest (ch0) must win.
    idle(); in_valid = 1; dec_rs1 = 5; dec_use1 = 1;
    fwd_valid = 2'b11; fwd_wb = 2'b11; fwd_wd = {5'd5, 5'd5}; fwd_data = {64'h22, 64'h11};
    step("fwd_prio", r, v);
    chk("fwd_prio rs1", bus.out_rs1_val, 64'h11);

    // A forward targeting x0 must not reach the operand.
    idle(); in_valid = 1; dec_rs2 = 0; dec_use2 = 1;
    fwd_valid = 2'b01; fwd_wb = 2'b01; fwd_wd = '0; fwd_data = {64'h0, 64'hFF};
    step("fwd_x0", r, v);
    chk("fwd_x0 rs2", bus.out_rs2_val, 64'h0);

    // Upstream exception outranks an illegal encoding.
    idle(); in_valid = 1; in_exc_valid = 1; in_exc_code = 4'd1; dec_illegal = 1;
    step("exc_prio", r, v);
    chk("exc_prio code", bus.out_exc_code, 4'd1);

    // Load into x7 followed by a consumer of x7.
    idle(); in_valid = 1; dec_wd = 7; dec_wb = 1; dec_mem_read = 1;
    step("load", r, v);
    idle(); in_valid = 1; dec_rs1 = 7; dec_use1 = 1; dec_wd = 3; dec_wb = 1;
    lows = 0; bubbles = 0; accepted = 0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      step("luse", r, v);
      if (r) accepted = 1;
      else begin
        lows++;
        if (!v) bubbles++;
      end
    end
    chk("luse accepted", accepted, 1'b1);
    chk("luse ready_low_cycles", lows, 3);
    chk("luse bubbles", bubbles, 2);

    // Downstream back-pressure for three cycles.
    idle(); in_valid = 1;
    step("pre_stall", r, v);
    idle(); in_valid = 1; bus.out_ready = 0;
    lows = 0;
    for (int k = 0; k < 3; k++) begin
      step("stall", r, v);
      if (!r) lows++;
    end
    chk("stall ready_low_cycles", lows, 3);
    bus.out_ready = 1;
    step("unstall", r, v);

    // Flush while the interlock is counting down.
    idle(); in_valid = 1; dec_wd = 7; dec_wb = 1; dec_mem_read = 1;
    step("load2", r, v);
    idle(); in_valid = 1; dec_rs1 = 7; dec_use1 = 1; dec_wd = 4; dec_wb = 1;
    step("hazard2", r, v);
    flush = 1;
    step("flush_luse", r, v);
    flush = 0;
    step("post_flush", r, v);
    chk("post_flush out_valid", v, 1'b0);
    chk("post_flush in_ready", r, 1'b1);
    idle();
    step("post_flush_out", r, v);

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      step("rand", r, v);
    end

    idle();
    for (int n = 0; n < 6; n++) step("drain", r, v);
    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
